// File: rtl/mem_lsu_if.sv
// Data-bus handshake between the MEM-stage LSU (master) and data memory (slave).
// Request fields are held stable by the master until ack.
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per memory op, store lane alignment,
// load extension, LL/SC link bit handling, misalignment detection and pipeline stall.
module mem_lsu #(
    parameter int unsigned BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    input  logic        in_we,
    input  logic [4:0]  in_waddr,
    input  logic [31:0] in_wdata,
    input  logic        llbit_in,
    mem_lsu_if.master   dbus,
    output logic        wp_we,
    output logic [4:0]  wp_waddr,
    output logic [31:0] wp_wdata,
    output logic        llbit_we,
    output logic        llbit_wdata,
    output logic        stall_req,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr,
    output logic        bus_err
);
    typedef enum logic [1:0] {StIdle, StReq, StDrain, StDone} state_e;

    localparam logic [3:0] OpLb = 4'd1, OpLbu = 4'd2, OpLh = 4'd3, OpLhu = 4'd4;
    localparam logic [3:0] OpLw = 4'd5, OpLl = 4'd6, OpSb = 4'd8, OpSh = 4'd9;
    localparam logic [3:0] OpSw = 4'd10, OpSc = 4'd11;

    state_e      state_q, state_d;
    logic        dbus_req_q, dbus_req_d, dbus_we_q, dbus_we_d;
    logic [31:0] dbus_addr_q, dbus_addr_d, dbus_wdata_q, dbus_wdata_d;
    logic [3:0]  dbus_be_q, dbus_be_d;
    logic [31:0] rdata_q, rdata_d, cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d, kill_q, kill_d;

    logic        is_load, is_store, sz_byte, sz_half, sz_word;
    logic        is_ll, is_sc, misaligned, sc_fail, kill, issue, timeout_hit;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, shifted, load_data;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_byte  = 1'b0;
        sz_half  = 1'b0;
        sz_word  = 1'b0;
        case (mem_op)
            OpLb, OpLbu: begin is_load  = 1'b1; sz_byte = 1'b1; end
            OpLh, OpLhu: begin is_load  = 1'b1; sz_half = 1'b1; end
            OpLw, OpLl:  begin is_load  = 1'b1; sz_word = 1'b1; end
            OpSb:        begin is_store = 1'b1; sz_byte = 1'b1; end
            OpSh:        begin is_store = 1'b1; sz_half = 1'b1; end
            OpSw, OpSc:  begin is_store = 1'b1; sz_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_ll      = (mem_op == OpLl);
    assign is_sc      = (mem_op == OpSc);
    assign misaligned = (sz_half & mem_addr[0]) | (sz_word & (|mem_addr[1:0]));
    assign sc_fail    = is_sc & ~llbit_in;
    // kill_q covers the cycle after a drain or timeout: that instruction must not retry.
    assign kill       = flush | kill_q;
    assign issue      = (state_q == StIdle) & (is_load | is_store) & ~misaligned
                        & ~sc_fail & ~kill;
    assign timeout_hit = (BUS_TIMEOUT != 0) && ((cnt_q + 32'd1) == BUS_TIMEOUT);

    assign be_calc    = sz_byte ? (4'b0001 << mem_addr[1:0]) :
                        sz_half ? (4'b0011 << mem_addr[1:0]) : 4'b1111;
    assign wdata_calc = sz_byte ? {4{mem_sdata[7:0]}} :
                        sz_half ? {2{mem_sdata[15:0]}} : mem_sdata;

    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        rdata_d      = rdata_q;
        cnt_d        = cnt_q;
        bus_err_d    = 1'b0;
        kill_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d      = StReq;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = is_store;
                    dbus_addr_d  = {mem_addr[31:2], 2'b00};
                    dbus_be_d    = be_calc;
                    dbus_wdata_d = wdata_calc;
                    cnt_d        = 32'd0;
                end
            end
            StReq, StDrain: begin
                if (dbus.ack) begin
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    if (state_q == StReq && !flush) begin
                        state_d = StDone;
                        rdata_d = dbus.rdata;
                    end else begin
                        state_d = StIdle;
                        kill_d  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d    = StIdle;
                    dbus_req_d = 1'b0;
                    dbus_we_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    kill_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (state_q == StReq && flush) state_d = StDrain;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= 32'd0;
            dbus_be_q    <= 4'd0;
            dbus_wdata_q <= 32'd0;
            rdata_q      <= 32'd0;
            cnt_q        <= 32'd0;
            bus_err_q    <= 1'b0;
            kill_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            rdata_q      <= rdata_d;
            cnt_q        <= cnt_d;
            bus_err_q    <= bus_err_d;
            kill_q       <= kill_d;
        end
    end

    assign dbus.req   = dbus_req_q;
    assign dbus.we    = dbus_we_q;
    assign dbus.addr  = dbus_addr_q;
    assign dbus.be    = dbus_be_q;
    assign dbus.wdata = dbus_wdata_q;
    assign bus_err    = bus_err_q;

    assign shifted = rdata_q >> {mem_addr[1:0], 3'b000};
    always_comb begin
        case (mem_op)
            OpLb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            OpLbu:   load_data = {24'd0, shifted[7:0]};
            OpLh:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            OpLhu:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        wp_waddr    = in_waddr;
        wp_wdata    = in_wdata;
        wp_we       = 1'b0;
        llbit_we    = 1'b0;
        llbit_wdata = 1'b0;
        if (!(is_load || is_store)) begin
            wp_we = in_we;
        end else if (misaligned) begin
            wp_we = 1'b0;
        end else if (state_q == StDone) begin
            if (is_load) begin
                wp_we    = 1'b1;
                wp_wdata = load_data;
            end
            if (is_ll) begin
                llbit_we    = 1'b1;
                llbit_wdata = 1'b1;
            end
            if (is_sc) begin
                wp_we    = 1'b1;
                wp_wdata = 32'd1;
                llbit_we = 1'b1;
            end
        end else if (state_q == StIdle && sc_fail) begin
            wp_we    = 1'b1;
            wp_wdata = 32'd0;
        end
        if (kill) begin
            wp_we    = 1'b0;
            llbit_we = 1'b0;
        end
    end

    assign exc_adel  = is_load & misaligned & ~kill;
    assign exc_ades  = is_store & misaligned & ~kill;
    assign badvaddr  = (exc_adel | exc_ades) ? mem_addr : 32'd0;
    assign stall_req = issue | (state_q == StReq) | (state_q == StDrain);
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: per-feature tasks with inline checks plus a writeback scoreboard
// (expected entries queued at stimulus time, observed entries queued by a monitor).
module tb_mem_lsu;
    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4, OP_LW = 4'd5, OP_LL = 4'd6, OP_SB = 4'd8;
    localparam logic [3:0] OP_SH = 4'd9, OP_SW = 4'd10, OP_SC = 4'd11;

    typedef struct packed {
        logic        wp_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        llbit_we;
        logic        llbit_wdata;
    } wb_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] mem_addr = 32'd0, mem_sdata = 32'd0, in_wdata = 32'd0;
    logic        in_we = 1'b0, llbit_in = 1'b0;
    logic [4:0]  in_waddr = 5'd0;
    logic        wp_we, llbit_we, llbit_wdata, stall_req, exc_adel, exc_ades, bus_err;
    logic [4:0]  wp_waddr;
    logic [31:0] wp_wdata, badvaddr;

    mem_lsu_if dbus ();

    mem_lsu #(.BUS_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_sdata(mem_sdata), .in_we(in_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
        .llbit_in(llbit_in), .dbus(dbus), .wp_we(wp_we), .wp_waddr(wp_waddr),
        .wp_wdata(wp_wdata), .llbit_we(llbit_we), .llbit_wdata(llbit_wdata),
        .stall_req(stall_req), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .badvaddr(badvaddr), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad = 0;
    wb_t sb_exp[$];
    wb_t sb_obs[$];

    logic        obs_stall[16], obs_req[16], obs_we[16], obs_berr[16];
    logic        obs_wpwe[16], obs_llwe[16], obs_adel[16], obs_ades[16];
    logic [3:0]  obs_be[16];
    logic [31:0] obs_addr[16], obs_wdata[16], obs_bva[16];

    always @(negedge clk) begin
        if (!rst && (wp_we || llbit_we))
            sb_obs.push_back(wb_t'{wp_we, wp_waddr, wp_wdata, llbit_we, llbit_wdata});
    end

    initial begin
        dbus.ack   = 1'b0;
        dbus.rdata = 32'd0;
    end

    task automatic set_op(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] waddr);
        mem_op    = op;
        mem_addr  = addr;
        mem_sdata = sdata;
        in_waddr  = waddr;
    endtask

    // Runs n cycles from the current inputs, recording outputs at each falling edge.
    task automatic capture(input int n, input int ack_at, input int none_at,
                           input int fl_from, input int fl_to);
        for (int c = 0; c < n; c++) begin
            dbus.ack = (c == ack_at);
            flush    = (c >= fl_from) && (c < fl_to);
            if (c == none_at) mem_op = OP_NONE;
            @(negedge clk);
            obs_stall[c] = stall_req;
            obs_req[c]   = dbus.req;
            obs_we[c]    = dbus.we;
            obs_be[c]    = dbus.be;
            obs_addr[c]  = dbus.addr;
            obs_wdata[c] = dbus.wdata;
            obs_berr[c]  = bus_err;
            obs_wpwe[c]  = wp_we;
            obs_llwe[c]  = llbit_we;
            obs_adel[c]  = exc_adel;
            obs_ades[c]  = exc_ades;
            obs_bva[c]   = badvaddr;
            @(posedge clk);
            #1;
        end
        dbus.ack = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (dbus.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", dbus.req); end
        total++; if (dbus.we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", dbus.we); end
        total++; if (dbus.addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", dbus.addr); end
        total++; if (dbus.be !== 4'd0) begin bad++; $display("FAIL reset_be got=%b exp=0", dbus.be); end
        total++; if (dbus.wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", dbus.wdata); end
        total++; if (bus_err !== 1'b0 || stall_req !== 1'b0) begin
            bad++; $display("FAIL reset_err_stall got=%b%b exp=00", bus_err, stall_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_passthrough();
        in_we    = 1'b1;
        in_waddr = 5'd7;
        in_wdata = 32'hCAFE_0001;
        sb_exp.push_back(wb_t'{1'b1, 5'd7, 32'hCAFE_0001, 1'b0, 1'b0});
        capture(1, -1, -1, 0, 0);
        total++; if (obs_wpwe[0] !== 1'b1 || obs_stall[0] !== 1'b0) begin
            bad++; $display("FAIL pass_we_stall got=%b%b exp=10", obs_wpwe[0], obs_stall[0]);
        end
        capture(1, -1, -1, 0, 1);
        total++; if (obs_wpwe[0] !== 1'b0) begin bad++; $display("FAIL pass_flush_we got=%b exp=0", obs_wpwe[0]); end
        in_we = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } ld_t;

    task automatic test_load_ext();
        ld_t  tbl[6];
        logic [3:0] st;
        tbl[0] = '{OP_LB,  32'h1003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80};
        tbl[1] = '{OP_LBU, 32'h1001, 32'h80FF_1234, 4'b0010, 32'h0000_0012};
        tbl[2] = '{OP_LH,  32'h1002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF};
        tbl[3] = '{OP_LHU, 32'h1002, 32'h80FF_1234, 4'b1100, 32'h0000_80FF};
        tbl[4] = '{OP_LB,  32'h1000, 32'h0000_00F0, 4'b0001, 32'hFFFF_FFF0};
        tbl[5] = '{OP_LW,  32'h1004, 32'h89AB_CDEF, 4'b1111, 32'h89AB_CDEF};
        for (int i = 0; i < 6; i++) begin
            set_op(tbl[i].op, tbl[i].addr, 32'd0, 5'd10);
            dbus.rdata = tbl[i].rdata;
            sb_exp.push_back(wb_t'{1'b1, 5'd10, tbl[i].exp, 1'b0, 1'b0});
            capture(4, 1, 3, 0, 0);
            st = {obs_stall[0], obs_stall[1], obs_stall[2], obs_stall[3]};
            total++; if (st !== 4'b1100) begin bad++; $display("FAIL load%0d_stall got=%b exp=1100", i, st); end
            total++; if (obs_req[1] !== 1'b1 || obs_we[1] !== 1'b0 || obs_be[1] !== tbl[i].be ||
                         obs_addr[1] !== (tbl[i].addr & 32'hFFFF_FFFC)) begin
                bad++; $display("FAIL load%0d_bus got=req%b we%b be%b a%h exp=req1 we0 be%b a%h", i,
                    obs_req[1], obs_we[1], obs_be[1], obs_addr[1], tbl[i].be, tbl[i].addr & 32'hFFFF_FFFC);
            end
        end
    endtask

    task automatic test_store();
        int         nreq = 0;
        logic [6:0] st;
        set_op(OP_SH, 32'h2002, 32'h0000_ABCD, 5'd11);
        capture(7, 4, 6, 0, 0);
        for (int c = 0; c < 7; c++) begin
            nreq += int'(obs_req[c]);
            st[6-c] = obs_stall[c];
        end
        total++; if (nreq != 4) begin bad++; $display("FAIL sh_req_cycles got=%0d exp=4", nreq); end
        total++; if (st !== 7'b1111100) begin bad++; $display("FAIL sh_stall got=%b exp=1111100", st); end
        for (int c = 1; c <= 4; c++) begin
            total++; if (obs_be[c] !== 4'b1100 || obs_wdata[c] !== 32'hABCD_ABCD || obs_we[c] !== 1'b1 ||
                         obs_addr[c] !== 32'h2000) begin
                bad++; $display("FAIL sh_bus_c%0d got=be%b d%h we%b a%h exp=be1100 dABCDABCD we1 a2000",
                    c, obs_be[c], obs_wdata[c], obs_we[c], obs_addr[c]);
            end
        end
        total++; if (obs_wpwe[5] !== 1'b0) begin bad++; $display("FAIL sh_wp_we got=%b exp=0", obs_wpwe[5]); end
        set_op(OP_SB, 32'h3001, 32'h1234_565A, 5'd12);
        capture(4, 1, 3, 0, 0);
        total++; if (obs_be[1] !== 4'b0010 || obs_wdata[1] !== 32'h5A5A_5A5A) begin
            bad++; $display("FAIL sb_bus got=be%b d%h exp=be0010 d5A5A5A5A", obs_be[1], obs_wdata[1]);
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  ops[6];
        logic [31:0] adrs[6];
        logic        adel[6];
        ops = '{OP_LW, OP_SW, OP_LH, OP_SH, OP_LL, OP_SC};
        adrs = '{32'h6, 32'h2, 32'h1, 32'h3, 32'h102, 32'h101};
        adel = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        llbit_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_op(ops[i], adrs[i], 32'hFFFF_FFFF, 5'd13);
            capture(2, -1, 1, 0, 0);
            total++; if (obs_adel[0] !== adel[i] || obs_ades[0] !== !adel[i] || obs_bva[0] !== adrs[i]) begin
                bad++; $display("FAIL mis%0d_exc got=l%b s%b v%h exp=l%b s%b v%h", i, obs_adel[0],
                    obs_ades[0], obs_bva[0], adel[i], !adel[i], adrs[i]);
            end
            total++; if (obs_stall[0] !== 1'b0 || obs_req[0] !== 1'b0 || obs_req[1] !== 1'b0 ||
                         obs_wpwe[0] !== 1'b0) begin
                bad++; $display("FAIL mis%0d_quiet got=st%b rq%b%b we%b exp=0 00 0", i, obs_stall[0],
                    obs_req[0], obs_req[1], obs_wpwe[0]);
            end
        end
        set_op(OP_LW, 32'h6, 32'd0, 5'd13);
        capture(1, -1, -1, 0, 1);
        mem_op = OP_NONE;
        total++; if (obs_adel[0] !== 1'b0 || obs_bva[0] !== 32'd0) begin
            bad++; $display("FAIL mis_flush got=l%b v%h exp=l0 v0", obs_adel[0], obs_bva[0]);
        end
    endtask

    task automatic test_ll_sc();
        dbus.rdata = 32'hDEAD_BEEF;
        set_op(OP_LL, 32'h100, 32'd0, 5'd4);
        sb_exp.push_back(wb_t'{1'b1, 5'd4, 32'hDEAD_BEEF, 1'b1, 1'b1});
        capture(4, 1, 3, 0, 0);
        total++; if (obs_llwe[2] !== 1'b1) begin bad++; $display("FAIL ll_llbit_we got=%b exp=1", obs_llwe[2]); end
        llbit_in = 1'b1;
        set_op(OP_SC, 32'h100, 32'h5555_AAAA, 5'd9);
        sb_exp.push_back(wb_t'{1'b1, 5'd9, 32'd1, 1'b1, 1'b0});
        capture(4, 1, 3, 0, 0);
        total++; if (obs_req[1] !== 1'b1 || obs_we[1] !== 1'b1 || obs_be[1] !== 4'b1111 ||
                     obs_wdata[1] !== 32'h5555_AAAA) begin
            bad++; $display("FAIL sc_bus got=rq%b we%b be%b d%h exp=rq1 we1 be1111 d5555AAAA",
                obs_req[1], obs_we[1], obs_be[1], obs_wdata[1]);
        end
        llbit_in = 1'b0;
        set_op(OP_SC, 32'h100, 32'h5555_AAAA, 5'd9);
        sb_exp.push_back(wb_t'{1'b1, 5'd9, 32'd0, 1'b0, 1'b0});
        capture(2, -1, 1, 0, 0);
        total++; if (obs_req[0] !== 1'b0 || obs_req[1] !== 1'b0 || obs_stall[0] !== 1'b0) begin
            bad++; $display("FAIL scfail_nobus got=rq%b%b st%b exp=rq00 st0", obs_req[0], obs_req[1],
                obs_stall[0]);
        end
    endtask

    task automatic test_flush_drain();
        logic [6:0] st, rq;
        int         writes = 0;
        dbus.rdata = 32'h1111_2222;
        set_op(OP_LL, 32'h40, 32'd0, 5'd6);
        capture(7, 4, 5, 1, 2);
        for (int c = 0; c < 7; c++) begin
            st[6-c] = obs_stall[c];
            rq[6-c] = obs_req[c];
            writes += int'(obs_wpwe[c]) + int'(obs_llwe[c]);
        end
        total++; if (st !== 7'b1111100) begin bad++; $display("FAIL drain_stall got=%b exp=1111100", st); end
        total++; if (rq !== 7'b0111100) begin bad++; $display("FAIL drain_req got=%b exp=0111100", rq); end
        total++; if (writes != 0) begin bad++; $display("FAIL drain_writes got=%0d exp=0", writes); end
    endtask

    task automatic test_timeout_reset();
        int nerr = 0;
        set_op(OP_LW, 32'h80, 32'd0, 5'd2);
        capture(12, -1, 9, 0, 0);
        for (int c = 0; c < 12; c++) begin
            total++; if (obs_req[c] !== (c >= 1 && c <= 8) || obs_stall[c] !== (c <= 8) ||
                         obs_berr[c] !== (c == 9) || obs_wpwe[c] !== 1'b0) begin
                nerr++;
                $display("FAIL timeout_c%0d got=rq%b st%b be%b we%b exp=rq%b st%b be%b we0", c,
                    obs_req[c], obs_stall[c], obs_berr[c], obs_wpwe[c], (c >= 1 && c <= 8),
                    (c <= 8), (c == 9));
            end
        end
        bad += nerr;
        set_op(OP_LW, 32'h84, 32'd0, 5'd2);
        capture(3, -1, -1, 0, 0);
        total++; if (obs_req[2] !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b exp=1", obs_req[2]); end
        rst = 1'b1;
        @(posedge clk);
        #1 mem_op = OP_NONE;
        @(negedge clk);
        total++; if (dbus.req !== 1'b0) begin bad++; $display("FAIL rstmid_req got=%b exp=0", dbus.req); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_writebacks();
        wb_t e, o;
        while (sb_exp.size() > 0) begin
            e = sb_exp.pop_front();
            total++;
            if (sb_obs.size() == 0) begin
                bad++; $display("FAIL wb_missing got=none exp=%h", e);
            end else begin
                o = sb_obs.pop_front();
                if (o !== e) begin bad++; $display("FAIL wb_entry got=%h exp=%h", o, e); end
            end
        end
        total++; if (sb_obs.size() != 0) begin
            bad++; $display("FAIL wb_extra got=%0d exp=0", sb_obs.size());
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_ext();
        test_store();
        test_misaligned();
        test_ll_sc();
        test_flush_drain();
        test_timeout_reset();
        test_writebacks();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit; sits directly upstream of the MEM/WB pipeline register.
- Runs one data-bus transaction per memory instruction: aligns stores, extends loads, handles LL/SC link bit, detects misalignment.
- Produces the MEM-stage register write port and LLbit write fields that MEM/WB latches.
- Requests a pipeline stall while a transaction is outstanding.

Parameters:
BUS_TIMEOUT, 0, cycles to wait for dbus_ack in REQ before raising bus_err; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill current MEM instruction
mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LL, 8 SB, 9 SH, 10 SW, 11 SC; other codes = NONE
mem_addr  in  32  effective address
mem_sdata  in  32  store data (rt)
in_we / in_waddr / in_wdata  in  1/5/32  EX-result write port (rt/rd, ALU data)
llbit_in  in  1  current LLbit, already forwarded from WB
dbus_req  out  1  bus request, registered
dbus_we  out  1  1 = store
dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-replicated store data
dbus_ack  in  1  transaction complete
dbus_rdata  in  32  read data, valid with ack
wp_we / wp_waddr / wp_wdata  out  1/5/32  write port to MEM/WB
llbit_we / llbit_wdata  out  1/1  LLbit update to MEM/WB
stall_req  out  1  hold pipeline (MEM and earlier)
exc_adel / exc_ades  out  1/1  load / store address error
badvaddr  out  32  = mem_addr when exc_* is 1, else 0
bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE, dbus_req/dbus_we 0, dbus_addr/be/wdata 0, rdata buffer 0, timeout counter 0, bus_err 0. Reset mid-transaction drops dbus_req on the next edge; no writeback occurs.
- Misalignment (combinational):
  - halfword ops: addr[0] != 0.
  - LW/LL/SW/SC: addr[1:0] != 0.
  - Misaligned load raises exc_adel; misaligned store raises exc_ades.
  - On misalignment: no bus access, stall_req 0, wp_we 0, llbit_we 0.
- SC with llbit_in = 0: no bus access, no stall; wp_we 1, wp_wdata 0, llbit_we 0.
- States:
  - IDLE: on a valid aligned access with flush 0, register the bus outputs and go to REQ.
  - REQ: hold dbus_req and the bus fields stable. On dbus_ack, capture dbus_rdata, drop dbus_req on the next edge, go to DONE. If flush arrives while in REQ, go to DRAIN.
  - DRAIN: the transaction cannot be aborted. Wait for ack, discard the data, go to IDLE. stall_req stays 1, and all writes are suppressed in DRAIN and in the following IDLE cycle.
  - DONE: one cycle, stall_req 0 so MEM/WB captures the result, then go to IDLE.
- stall_req = access pending AND state is not DONE. This includes the IDLE issue cycle, REQ and DRAIN.
- Minimum occupancy is 3 cycles with same-cycle ack (IDLE→REQ→DONE).
- Byte lanes, little-endian:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{sdata[7:0]}}.
  - half: be = 4'b0011 << addr[1:0], wdata = {2{sdata[15:0]}}.
  - word: be = 4'b1111.
  - Loads drive be per width as well.
- Load result in DONE: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. wp_we 1, wp_waddr = in_waddr.
- LL: as LW, plus llbit_we 1, llbit_wdata 1 in DONE.
- SC success (DONE): wp_wdata 1, llbit_we 1, llbit_wdata 0.
- Plain stores: wp_we 0.
- mem_op NONE: wp = in_* pass-through; llbit_we 0; stall_req 0.
- flush: when flush is 1, wp_we, llbit_we and exc_* are all 0.
- Timeout: counter resets on entry to REQ. If it reaches BUS_TIMEOUT without ack, pulse bus_err, drop dbus_req, go to IDLE with no writeback.

Test Plan:
- LB addr 0x1003, rdata 0x80FF_1234 with immediate ack → dbus_be 4'b1000; stall_req 1,1,0; DONE wp_wdata 0xFFFF_FF80.
- SH addr 0x2002, sdata 0x0000_ABCD, ack after 4 cycles → be 4'b1100, wdata 0xABCD_ABCD; dbus_req held 4 cycles; wp_we 0.
- LW addr 0x0006 → exc_adel 1, badvaddr 0x0000_0006, dbus_req never 1, stall_req 0.
- LL 0x100 then SC 0x100 with llbit_in 1 → LL gives llbit_we/wdata 1/1; SC gives bus store, wp_wdata 1, llbit 1/0. Repeat SC with llbit_in 0 → wp_wdata 0, no bus.
- flush during REQ with ack 3 cycles later → DRAIN; stall_req high until ack; no wp_we/llbit_we pulse.
- BUS_TIMEOUT = 8, no ack → bus_err pulse after 8 REQ cycles, dbus_req 0, stall_req released; rst asserted mid-REQ → dbus_req 0 on the next edge.
